// File: rtl/fx_pkg.sv
// Shared fixed-point definitions for the A(Ent,Frac) datapath: default format,
// unity constant, accumulator state encoding and saturation bounds.
package fx_pkg;

    localparam int WIDTH = 32;
    localparam int ENT   = 9;
    localparam int FRAC  = 22;

    localparam logic [WIDTH-1:0] FX_ONE = WIDTH'(1) << FRAC;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

    // Largest and smallest signed values representable in w bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fx_sat.sv
// Combinational signed saturation from InW to OutW bits, with a flag that
// reports whether the value had to be clipped.
module fx_sat
    import fx_pkg::*;
#(
    parameter int InW  = 34,
    parameter int OutW = 32
) (
    input  logic signed [InW-1:0]  in_data,
    output logic        [OutW-1:0] out_data,
    output logic                   clip
);

    localparam logic signed [InW-1:0] MAX_IN = InW'(sat_max(OutW));
    localparam logic signed [InW-1:0] MIN_IN = InW'(sat_min(OutW));

    // NOTE: every output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        out_data = in_data[OutW-1:0];
        clip     = 1'b0;
        if (in_data > MAX_IN) begin
            out_data = MAX_IN[OutW-1:0];
            clip     = 1'b1;
        end else if (in_data < MIN_IN) begin
            out_data = MIN_IN[OutW-1:0];
            clip     = 1'b1;
        end
    end

endmodule

// File: rtl/fx_acc_stream.sv
// Streaming fixed-point accumulator: sums Terms consecutive products into one
// saturated result, with valid/ready handshakes on input and output.
module fx_acc_stream
    import fx_pkg::*;
#(
    parameter int Width = WIDTH,
    parameter int Terms = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] sum_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             sat_o
);

    localparam int CW = $clog2(Terms);
    localparam int AW = Width + CW;
    localparam logic [CW-1:0] LAST = CW'(Terms - 1);

    acc_state_e            state_q, state_d;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  total;
    logic        [CW-1:0]  cnt_q;
    logic        [Width-1:0] sat_data;
    logic                  sat_clip;
    logic                  beat;
    logic                  last_beat;

    assign in_ready_o = (state_q == ST_ACC);
    // A beat offered while clear_i is high is dropped, never accumulated.
    assign beat       = in_valid_i & in_ready_o & ~clear_i;
    assign last_beat  = beat & (cnt_q == LAST);
    // Headroom of $clog2(Terms) bits means the wide sum cannot wrap.
    assign total      = acc_q + AW'(signed'(in_data_i));

    fx_sat #(
        .InW  (AW),
        .OutW (Width)
    ) u_sat (
        .in_data  (total),
        .out_data (sat_data),
        .clip     (sat_clip)
    );

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_ACC;
        end else begin
            case (state_q)
                ST_ACC:  if (last_beat)   state_d = ST_HOLD;
                ST_HOLD: if (sum_ready_i) state_d = ST_ACC;
                default: state_d = ST_ACC;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_o       <= '0;
            sum_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else if (clear_i) begin
            // sum_o is deliberately left alone; only its qualifiers drop.
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else if (last_beat) begin
            sum_o       <= sat_data;
            sat_o       <= sat_clip;
            sum_valid_o <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else if (beat) begin
            acc_q       <= total;
            cnt_q       <= cnt_q + CW'(1);
        end else if (state_q == ST_HOLD && sum_ready_i) begin
            sum_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fx_acc_stream.sv
// Self-checking bench for fx_acc_stream (Width=32, Terms=4): vector table,
// hand-written corner sequences and a randomized scoreboard run.
module tb_fx_acc_stream;

    localparam int W = 32;
    localparam int T = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    localparam logic [31:0] ONE   = 32'h0040_0000;
    localparam logic [31:0] TWO   = 32'h0080_0000;
    localparam logic [31:0] HALF  = 32'h0020_0000;
    localparam logic [31:0] QTR   = 32'h0010_0000;
    localparam logic [31:0] M_ONE = 32'hFFC0_0000;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [W-1:0]  in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [W-1:0]  sum_o;
    logic          sum_valid_o;
    logic          sum_ready_i = 1'b0;
    logic          sat_o;

    int n_cmp  = 0;
    int n_fail = 0;

    fx_acc_stream #(.Width(W), .Terms(T)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sum_o       (sum_o),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .sat_o       (sat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string           name;
        logic [3:0][31:0] d;
        logic [31:0]     s;
        logic            c;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d,
                                input logic [31:0] s, input logic clip);
        vec_t v;
        v.name = n;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d;
        v.s = s;
        v.c = clip;
        return v;
    endfunction

    // Reference: exact sum in 64-bit arithmetic, then clamp to the 32-bit range.
    function automatic void ref_sum(input logic [3:0][31:0] d, output logic [31:0] s,
                                    output logic c);
        longint t = 0;
        for (int i = 0; i < T; i++) t += longint'(signed'(d[i]));
        c = 1'b1;
        if (t > MAXV)      s = 32'h7FFF_FFFF;
        else if (t < MINV) s = 32'h8000_0000;
        else begin
            s = t[31:0];
            c = 1'b0;
        end
    endfunction

    function automatic logic [31:0] gen_data();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFFF - $urandom_range(0, 255);
            1:       return 32'h8000_0000 + $urandom_range(0, 255);
            2:       return 32'($signed($urandom_range(0, 32'h0200_0000)) - 32'sh0100_0000);
            default: return $urandom;
        endcase
    endfunction

    task automatic send_group(input logic [3:0][31:0] d);
        for (int j = 0; j < T; j++) begin
            in_valid_i = 1'b1;
            in_data_i  = d[j];
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic take_result();
        sum_ready_i = 1'b1;
        tick();
        sum_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_s;
        logic        exp_c;
        logic [31:0] part[$];
        logic [3:0][31:0] grp;
        bit          hold;
        bit          was_hold;
        int          got;
        int          cyc;

        vecs[0] = mk("basic",      ONE, TWO, 32'hFFE0_0000, QTR, 32'h00B0_0000, 1'b0);
        vecs[1] = mk("pos_sat",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                     32'h7FFF_FFFF, 1'b1);
        vecs[2] = mk("neg_sat",    32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                     32'h8000_0000, 1'b1);
        vecs[3] = mk("minus_four", M_ONE, M_ONE, M_ONE, M_ONE, 32'hFF00_0000, 1'b0);
        vecs[4] = mk("max_exact",  32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h1FFF_FFFF,
                     32'h7FFF_FFFF, 1'b0);
        vecs[5] = mk("max_plus1",  32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000,
                     32'h7FFF_FFFF, 1'b1);
        vecs[6] = mk("min_exact",  32'hE000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000,
                     32'h8000_0000, 1'b0);
        vecs[7] = mk("wide_wrap",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                     32'hFFFF_FFFE, 1'b0);

        // Reset state
        #12;
        check("rst_in_ready", in_ready_o, 1'b1);
        check("rst_sum_valid", sum_valid_o, 1'b0);
        check("rst_sum", sum_o, 32'h0);
        check("rst_sat", sat_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Vector table, back-to-back beats, including one-cycle latency
        foreach (vecs[k]) begin
            for (int j = 0; j < T; j++) begin
                check({vecs[k].name, "_ready"}, in_ready_o, 1'b1);
                check({vecs[k].name, "_early_valid"}, sum_valid_o, 1'b0);
                in_valid_i = 1'b1;
                in_data_i  = vecs[k].d[j];
                tick();
            end
            in_valid_i = 1'b0;
            check({vecs[k].name, "_valid"}, sum_valid_o, 1'b1);
            check({vecs[k].name, "_sum"}, sum_o, vecs[k].s);
            check({vecs[k].name, "_sat"}, sat_o, vecs[k].c);
            take_result();
            check({vecs[k].name, "_valid_drop"}, sum_valid_o, 1'b0);
        end

        // Gaps on the input, then back-pressure with an input still offered
        for (int j = 0; j < T; j++) begin
            in_valid_i = 1'b0;
            tick();
            in_valid_i = 1'b1;
            in_data_i  = HALF;
            tick();
        end
        in_data_i = 32'h7FFF_FFFF;
        for (int j = 0; j < 5; j++) begin
            check("hold_valid", sum_valid_o, 1'b1);
            check("hold_sum", sum_o, TWO);
            check("hold_ready", in_ready_o, 1'b0);
            tick();
        end
        take_result();
        in_valid_i = 1'b0;
        check("post_hs_ready", in_ready_o, 1'b1);
        grp = {QTR, QTR, QTR, QTR};
        send_group(grp);
        check("restart_sum", sum_o, ONE);
        check("restart_sat", sat_o, 1'b0);
        take_result();

        // Asynchronous reset after two beats
        grp = {ONE, ONE, ONE, ONE};
        in_valid_i = 1'b1;
        in_data_i  = ONE;
        tick();
        tick();
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        check("midrst_ready", in_ready_o, 1'b1);
        check("midrst_valid", sum_valid_o, 1'b0);
        check("midrst_sum", sum_o, 32'h0);
        rst_ni = 1'b1;
        tick();
        grp = {HALF, HALF, HALF, HALF};
        send_group(grp);
        check("after_rst_valid", sum_valid_o, 1'b1);
        check("after_rst_sum", sum_o, TWO);
        take_result();

        // clear_i together with beat 3
        in_valid_i = 1'b1;
        in_data_i  = ONE;
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        check("clr_valid", sum_valid_o, 1'b0);
        check("clr_ready", in_ready_o, 1'b1);
        grp = {M_ONE, M_ONE, M_ONE, M_ONE};
        send_group(grp);
        check("clr_sum", sum_o, 32'hFF00_0000);
        check("clr_sat", sat_o, 1'b0);
        check("clr_group_valid", sum_valid_o, 1'b1);
        take_result();

        // clear_i while a saturated result is held, with sum_ready_i also high
        grp = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        send_group(grp);
        check("hclr_pre_sat", sat_o, 1'b1);
        clear_i     = 1'b1;
        sum_ready_i = 1'b1;
        tick();
        clear_i     = 1'b0;
        sum_ready_i = 1'b0;
        check("hclr_valid", sum_valid_o, 1'b0);
        check("hclr_sat", sat_o, 1'b0);
        check("hclr_sum_kept", sum_o, 32'h7FFF_FFFF);
        check("hclr_ready", in_ready_o, 1'b1);

        // Randomized result-rate stress against the scoreboard
        hold = 1'b0;
        got  = 0;
        cyc  = 0;
        exp_s = '0;
        exp_c = 1'b0;
        while (got < 100 && cyc < 20000) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = gen_data();
            sum_ready_i = ($urandom_range(0, 2) != 0);
            check("rnd_ready", in_ready_o, !hold);
            check("rnd_valid", sum_valid_o, hold);
            was_hold = hold;
            if (was_hold && sum_ready_i) begin
                check("rnd_sum", sum_o, exp_s);
                check("rnd_sat", sat_o, exp_c);
                got++;
                hold = 1'b0;
            end
            if (!was_hold && in_valid_i) begin
                part.push_back(in_data_i);
                if (part.size() == T) begin
                    for (int i = 0; i < T; i++) grp[i] = part[i];
                    ref_sum(grp, exp_s, exp_c);
                    part.delete();
                    hold = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        in_valid_i  = 1'b0;
        sum_ready_i = 1'b0;
        check("rnd_result_count", got, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
